mean_square_u16: RTL and testbench
==================================

Name: mean_square_u16

Overview:
- Computes the mean square of a fixed-length window of unsigned 16-bit samples.
- Sits directly upstream of sqrt_u32: x/vld_out drive sqrt_u32 x/vld_in, and the pair forms the RMS path.
- Squaring uses a sequential shift-add multiplier, one bit per cycle. An upstream ready handshake throttles the sample rate.
- Has no downstream backpressure, because sqrt_u32 has no ready.

Parameters:
LOG2N, 4, log2 of window length N (N = 2^LOG2N samples per result); legal 1..8

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
vld_in  input  1  sample valid; accepted only when rdy=1
s  input  16  unsigned sample
rdy  output  1  block can accept a sample this cycle
vld_out  output  1  one-cycle pulse: x holds a new mean square
x  output  32  mean square of last window, to sqrt_u32 x

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE, rdy=1, vld_out=0, x=0, accumulator=0, sample count=0, multiplier regs=0. This applies from any state. An in-flight sample and a partial window are discarded.
- States: IDLE, MUL, ACC, OUT.
- IDLE: rdy=1.
  - vld_in=1 -> latch s as multiplicand and multiplier, clear product, bit counter=0, go to MUL.
  - vld_in=0 -> stay in IDLE.
- MUL: rdy=0, lasts exactly 16 cycles.
  - Each cycle: if the current multiplier LSB=1, add the shifted multiplicand to the 32-bit product. Then shift and increment the bit counter.
  - After count 15, go to ACC.
  - The product equals s*s exactly and never overflows 32 bits (max 0xFFFE0001).
- ACC: rdy=0, lasts 1 cycle.
  - accumulator += product. The accumulator is 32+LOG2N bits and cannot overflow.
  - sample count += 1.
  - If count reaches N, go to OUT; otherwise go to IDLE.
- OUT: rdy=0, lasts 1 cycle.
  - vld_out=1, x = accumulator >> LOG2N (truncating floor, always fits 32 bits).
  - accumulator and count cleared; go to IDLE.
- Timing: sample accepted at edge T (IDLE, vld_in=1). MUL occupies T+1..T+16, ACC T+17.
  - Non-final sample: rdy=1 again at T+18, giving a minimum 18-cycle sample period.
  - Final sample of window: vld_out=1 at T+18, rdy=1 at T+19.
- x is registered, updates only in OUT, and holds its value between pulses. vld_out is never high two consecutive cycles.
- vld_in while rdy=0: ignored. No queueing, no count change, no effect on s latch.
- s changes while busy: no effect (operand latched at accept).
- rst and vld_in in the same cycle: rst wins, sample not accepted.
- Windows are non-overlapping and back-to-back. The first sample after OUT starts a new window.
- Samples of 0 are valid and counted.

Test Plan:
1. Reset: rst=1 for 2 cycles, then 0 -> rdy=1, vld_out=0, x=0; no vld_out for 100 idle cycles.
2. LOG2N=4, 16 samples of 0xFFFF, each presented as soon as rdy=1 -> exactly one vld_out with x=0xFFFE0001 (sqrt_u32 then yields 0xFFFF).
   - Check vld_out at the 18th edge after the 16th accept.
   - Check rdy is low for 17 cycles after each accept (18 after the last).
3. Truncation: 15 samples of 1 and one of 2 (sum 19) -> x=1. Next window: 8 samples of 4 and 8 of 0 (sum 128) -> x=8. Results are independent across windows.
4. Busy-drop: hold vld_in=1 continuously with s incrementing every cycle starting at 0.
   - Only values present on rdy=1 cycles are accepted: s = 0, 18, 36, ... (18-cycle spacing).
   - x must equal floor of the sum of their squares over 16 samples.
5. Reset mid-operation: accept 5 samples of 100, assert rst during MUL of the 6th, release, then 16 samples of 2.
   - The first vld_out shows x=4; no residue from the aborted window.
6. LOG2N=1 build: samples 3 then 4 -> x=12 (floor 25/2); next pair 0xFFFF, 0xFFFF -> x=0xFFFE0001.

Source files
------------

// File: rtl/mean_square_u16.sv
// Mean square of non-overlapping windows of 2^LOG2N unsigned 16-bit samples.
// Squaring is a 16-cycle shift-add multiply; the result feeds sqrt_u32 for RMS.
module mean_square_u16 #(
    parameter int LOG2N = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vld_in,
    input  logic [15:0] s,
    output logic        rdy,
    output logic        vld_out,
    output logic [31:0] x
);

    localparam int ACC_W = 32 + LOG2N;
    localparam int CNT_W = LOG2N + 1;
    localparam int N     = 1 << LOG2N;

    typedef enum logic [1:0] {IDLE, MUL, ACC, OUT} state_t;

    state_t             state_reg;
    logic [31:0]        mcand_reg;
    logic [15:0]        mplier_reg;
    logic [31:0]        product_reg;
    logic [3:0]         bit_cnt_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [31:0]        x_reg;
    logic               vld_out_reg;
    logic               rdy_reg;

    logic [ACC_W-1:0]   acc_sum_next;
    logic [CNT_W-1:0]   count_inc_next;

    always_comb begin
        acc_sum_next   = acc_reg + ACC_W'(product_reg);
        count_inc_next = count_reg + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            product_reg <= '0;
            bit_cnt_reg <= '0;
            acc_reg     <= '0;
            count_reg   <= '0;
            x_reg       <= '0;
            vld_out_reg <= 1'b0;
            rdy_reg     <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (vld_in) begin
                        mcand_reg   <= {16'd0, s};
                        mplier_reg  <= s;
                        product_reg <= '0;
                        bit_cnt_reg <= '0;
                        rdy_reg     <= 1'b0;
                        state_reg   <= MUL;
                    end
                end
                MUL: begin
                    // One multiplier bit per cycle, LSB first, multiplicand shifted up.
                    if (mplier_reg[0])
                        product_reg <= product_reg + mcand_reg;
                    mcand_reg   <= {mcand_reg[30:0], 1'b0};
                    mplier_reg  <= {1'b0, mplier_reg[15:1]};
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg == 4'd15)
                        state_reg <= ACC;
                end
                ACC: begin
                    acc_reg   <= acc_sum_next;
                    count_reg <= count_inc_next;
                    if (count_inc_next == CNT_W'(N)) begin
                        // x and vld_out are registered on entry so they are valid during OUT.
                        x_reg       <= acc_sum_next[LOG2N +: 32];
                        vld_out_reg <= 1'b1;
                        state_reg   <= OUT;
                    end else begin
                        rdy_reg   <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                OUT: begin
                    vld_out_reg <= 1'b0;
                    acc_reg     <= '0;
                    count_reg   <= '0;
                    rdy_reg     <= 1'b1;
                    state_reg   <= IDLE;
                end
                default: begin
                    rdy_reg   <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign rdy     = rdy_reg;
    assign vld_out = vld_out_reg;
    assign x       = x_reg;

endmodule

// File: tb/tb_mean_square_u16.sv
// Directed bench for mean_square_u16: a LOG2N=4 instance and a LOG2N=1 instance.
`timescale 1ns/1ps
module tb_mean_square_u16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld_in = 1'b0;
    logic [15:0] s = 16'd0;
    logic        rdy, vld_out;
    logic [31:0] x;

    logic        vld_in2 = 1'b0;
    logic [15:0] s2 = 16'd0;
    logic        rdy2, vld_out2;
    logic [31:0] x2;

    int errors = 0;
    int checks = 0;
    bit sel = 1'b0;

    logic        rdy_m, vld_m;
    logic [31:0] x_m;
    assign rdy_m = sel ? rdy2 : rdy;
    assign vld_m = sel ? vld_out2 : vld_out;
    assign x_m   = sel ? x2 : x;

    mean_square_u16 #(.LOG2N(4)) dut (
        .clk(clk), .rst(rst), .vld_in(vld_in), .s(s),
        .rdy(rdy), .vld_out(vld_out), .x(x)
    );

    mean_square_u16 #(.LOG2N(1)) dut2 (
        .clk(clk), .rst(rst), .vld_in(vld_in2), .s(s2),
        .rdy(rdy2), .vld_out(vld_out2), .x(x2)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] val);
        if (sel) begin
            vld_in2 = v;
            s2      = val;
        end else begin
            vld_in = v;
            s      = val;
        end
    endtask

    // Presents one sample as soon as rdy=1 and checks the full busy/ready timeline.
    task automatic send(input logic [15:0] val, input bit last, input logic [31:0] exp_x);
        int w;
        w = 0;
        while (rdy_m !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        checks++;
        if (rdy_m !== 1'b1) begin
            errors++;
            $display("FAIL rdy_wait: rdy=%b required 1", rdy_m);
            return;
        end
        drive(1'b1, val);
        tick();
        drive(1'b0, ~val);
        for (int i = 1; i <= 17; i++) begin
            checks++;
            if (rdy_m !== 1'b0 || vld_m !== 1'b0) begin
                errors++;
                $display("FAIL busy cyc%0d: rdy=%b vld_out=%b required 0/0", i, rdy_m, vld_m);
            end
            tick();
        end
        if (last) begin
            checks++;
            if (vld_m !== 1'b1 || rdy_m !== 1'b0) begin
                errors++;
                $display("FAIL out_pulse: vld_out=%b rdy=%b required 1/0", vld_m, rdy_m);
            end
            checks++;
            if (x_m !== exp_x) begin
                errors++;
                $display("FAIL x_value: x=%h required %h", x_m, exp_x);
            end
            tick();
            checks++;
            if (vld_m !== 1'b0 || rdy_m !== 1'b1 || x_m !== exp_x) begin
                errors++;
                $display("FAIL after_out: vld_out=%b rdy=%b x=%h required 0/1/%h",
                         vld_m, rdy_m, x_m, exp_x);
            end
        end else begin
            checks++;
            if (rdy_m !== 1'b1 || vld_m !== 1'b0) begin
                errors++;
                $display("FAIL ready_again: rdy=%b vld_out=%b required 1/0", rdy_m, vld_m);
            end
        end
        $display("sample %h accepted (last=%0d) rdy_wait=%0d", val, last, w);
    endtask

    task automatic test_reset;
        bit seen;
        sel = 1'b0;
        rst = 1'b1;
        vld_in = 1'b1;
        s = 16'd5;
        vld_in2 = 1'b1;
        s2 = 16'd5;
        tick();
        tick();
        rst = 1'b0;
        vld_in = 1'b0;
        vld_in2 = 1'b0;
        checks++;
        if (rdy !== 1'b1 || vld_out !== 1'b0 || x !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld_out=%b x=%h required 1/0/0", rdy, vld_out, x);
        end
        checks++;
        if (rdy2 !== 1'b1 || vld_out2 !== 1'b0 || x2 !== 32'd0) begin
            errors++;
            $display("FAIL reset_state2: rdy=%b vld_out=%b x=%h required 1/0/0", rdy2, vld_out2, x2);
        end
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (vld_out !== 1'b0 || rdy !== 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL idle_quiet: activity=%b required 0", seen);
        end
        $display("reset: done");
    endtask

    task automatic test_full_scale;
        sel = 1'b0;
        for (int i = 0; i < 16; i++)
            send(16'hFFFF, i == 15, 32'hFFFE0001);
        $display("full_scale: done");
    endtask

    task automatic test_truncation;
        sel = 1'b0;
        for (int i = 0; i < 16; i++)
            send((i == 15) ? 16'd2 : 16'd1, i == 15, 32'd1);
        for (int i = 0; i < 16; i++) begin
            send((i < 8) ? 16'd4 : 16'd0, i == 15, 32'd8);
            if (i == 10) begin
                checks++;
                if (x !== 32'd1) begin
                    errors++;
                    $display("FAIL x_hold: x=%h required 1", x);
                end
            end
        end
        $display("truncation: done");
    endtask

    task automatic test_busy_drop;
        int n_seen;
        bit found;
        sel = 1'b0;
        found = 1'b0;
        n_seen = -1;
        s = 16'd0;
        vld_in = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (!found) begin
                tick();
                if (vld_out === 1'b1) begin
                    found = 1'b1;
                    n_seen = n;
                    vld_in = 1'b0;
                end else begin
                    s = 16'(n + 1);
                end
            end
        end
        vld_in = 1'b0;
        checks++;
        if (!found || n_seen != 287) begin
            errors++;
            $display("FAIL busy_drop_timing: vld_out edge=%0d required 287", n_seen);
        end
        checks++;
        if (x !== 32'd25110) begin
            errors++;
            $display("FAIL busy_drop_x: x=%0d required 25110", x);
        end
        tick();
        $display("busy_drop: vld_out at edge %0d x=%0d", n_seen, x);
    endtask

    task automatic test_reset_mid;
        sel = 1'b0;
        for (int i = 0; i < 5; i++)
            send(16'd100, 1'b0, 32'd0);
        drive(1'b1, 16'd100);
        tick();
        drive(1'b0, 16'd0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (rdy !== 1'b1 || vld_out !== 1'b0 || x !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: rdy=%b vld_out=%b x=%h required 1/0/0", rdy, vld_out, x);
        end
        for (int i = 0; i < 16; i++)
            send(16'd2, i == 15, 32'd4);
        $display("reset_mid: done");
    endtask

    task automatic test_log2n_1;
        sel = 1'b1;
        send(16'd3, 1'b0, 32'd0);
        send(16'd4, 1'b1, 32'd12);
        send(16'hFFFF, 1'b0, 32'd0);
        send(16'hFFFF, 1'b1, 32'hFFFE0001);
        sel = 1'b0;
        $display("log2n_1: done");
    endtask

    initial begin
        test_reset();
        test_full_scale();
        test_truncation();
        test_busy_drop();
        test_reset_mid();
        test_log2n_1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
